// File: rtl/addrcalcsec_chk_pkg.sv
// Shared definitions for the address-calc security bounds checker:
// pointer field layout, fault codes and the fault-priority helper.
package addrcalcsec_chk_pkg;

  localparam int unsigned ADDR_W = 44;
  localparam int unsigned PTR_W  = 65;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned IDX_W  = 7;

  // Pointer layout, MSB first; bit 64 is spare metadata carried through untouched.
  typedef struct packed {
    logic               rsvd;
    logic [EXP_W-1:0]   exp;
    logic [IDX_W-1:0]   low;
    logic [IDX_W-1:0]   hi;
    logic               on_low;
    logic [ADDR_W-1:0]  addr;
  } ptr_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_WIN   = 2'd1,
    FC_UPPER = 2'd2,
    FC_MALF  = 2'd3
  } fcode_e;

  // Fault classification in priority order: malformed, upper bits, window.
  function automatic fcode_e fault_code(
    input logic             chk_en,
    input logic             on_low,
    input logic [IDX_W-1:0] low,
    input logic [IDX_W-1:0] hi,
    input logic [IDX_W-1:0] idx,
    input logic             up_same
  );
    fcode_e fc;
    fc = FC_NONE;
    if (chk_en && on_low) begin
      if (hi < low)                    fc = FC_MALF;
      else if (!up_same)               fc = FC_UPPER;
      else if (idx < low || idx > hi)  fc = FC_WIN;
    end
    return fc;
  endfunction

endpackage

// File: rtl/addrcalcsec_chk_idx.sv
// Combinational window index and upper-bit extraction for one address:
// idx = addr[exp+11:exp+5], up = addr with all bits below exp+12 cleared.
module addrcalcsec_idx
  import addrcalcsec_chk_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [EXP_W-1:0]  i_exp,
  output logic [IDX_W-1:0]  o_idx,
  output logic [ADDR_W-1:0] o_up
);

  logic [ADDR_W-1:0] w_mask;

  // exp is at most 31, so the shift amounts stay within the address width.
  assign o_idx  = IDX_W'(i_addr >> (6'(i_exp) + 6'd5));
  assign w_mask = ~((ADDR_W'(1) << (6'(i_exp) + 6'd12)) - ADDR_W'(1));
  assign o_up   = i_addr & w_mask;

endmodule

// File: rtl/addrcalcsec_chk.sv
// Bounds checker for scaled bounded pointers: adds a signed displacement,
// checks the result against the pointer window and emits it through a
// 2-stage valid/ready pipeline.
// Optional: define ADDRCALCSEC_CHK_FCNT_EN to build the saturating fault counter;
// otherwise fault_cnt is tied to zero.
module addrcalcsec_chk
  import addrcalcsec_chk_pkg::*;
#(
  parameter int unsigned DISP_W = 32,
  parameter int unsigned TAG_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [PTR_W-1:0]  in_ptr,
  input  logic [DISP_W-1:0] in_disp,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_chk_en,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PTR_W-1:0]  out_ptr,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_fault,
  output logic [1:0]        out_fcode,
  output logic [15:0]       fault_cnt
);

  logic              r_s1_vld;
  ptr_t              r_s1_ptr;
  logic [ADDR_W-1:0] r_s1_sum;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_chk;

  logic              r_out_vld;
  logic [ADDR_W-1:0] r_out_addr;
  ptr_t              r_out_ptr;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_fault;
  fcode_e            r_out_fcode;

  logic              w_adv1;
  logic              w_adv2;
  logic [ADDR_W-1:0] w_disp_ext;
  logic [ADDR_W-1:0] w_sum;
  ptr_t              w_new_ptr;
  logic [IDX_W-1:0]  w_idx_new;
  logic [IDX_W-1:0]  w_unused_idx_old;
  logic [ADDR_W-1:0] w_up_new;
  logic [ADDR_W-1:0] w_up_old;
  fcode_e            w_fcode;

  assign w_adv2 = !r_out_vld || out_rdy;
  assign w_adv1 = w_adv2 || !r_s1_vld;
  assign in_rdy = w_adv1;

  // The adder wraps modulo 2^44; a wrap is only visible through the upper-bit check.
  assign w_disp_ext = ADDR_W'($signed(in_disp));
  assign w_sum      = in_ptr[ADDR_W-1:0] + w_disp_ext;

  // Valid bits for both stages; flush kills everything including a same-cycle input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else if (flush) begin
      r_s1_vld  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      if (w_adv1) r_s1_vld  <= in_vld;
      if (w_adv2) r_out_vld <= r_s1_vld;
    end
  end

  // Stage 1 payload: pointer, tag, enable and the wrapped sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_ptr <= '0;
      r_s1_sum <= '0;
      r_s1_tag <= '0;
      r_s1_chk <= 1'b0;
    end else if (w_adv1 && in_vld && !flush) begin
      r_s1_ptr <= ptr_t'(in_ptr);
      r_s1_sum <= w_sum;
      r_s1_tag <= in_tag;
      r_s1_chk <= in_chk_en;
    end
  end

  // Updated pointer: metadata unchanged, address replaced by the sum.
  always_comb begin
    w_new_ptr      = r_s1_ptr;
    w_new_ptr.addr = r_s1_sum;
  end

  // Only the upper bits of the original address matter; its window index is unused.
  addrcalcsec_idx u_idx_old (
    .i_addr (r_s1_ptr.addr),
    .i_exp  (r_s1_ptr.exp),
    .o_idx  (w_unused_idx_old),
    .o_up   (w_up_old)
  );

  addrcalcsec_idx u_idx_new (
    .i_addr (r_s1_sum),
    .i_exp  (r_s1_ptr.exp),
    .o_idx  (w_idx_new),
    .o_up   (w_up_new)
  );

  assign w_fcode = fault_code(r_s1_chk, r_s1_ptr.on_low, r_s1_ptr.low, r_s1_ptr.hi,
                              w_idx_new, (w_up_new == w_up_old));

  // Stage 2 payload: held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_addr  <= '0;
      r_out_ptr   <= '0;
      r_out_tag   <= '0;
      r_out_fault <= 1'b0;
      r_out_fcode <= FC_NONE;
    end else if (w_adv2 && r_s1_vld && !flush) begin
      r_out_addr  <= r_s1_sum;
      r_out_ptr   <= w_new_ptr;
      r_out_tag   <= r_s1_tag;
      r_out_fault <= (w_fcode != FC_NONE);
      r_out_fcode <= w_fcode;
    end
  end

  assign out_vld   = r_out_vld;
  assign out_addr  = r_out_addr;
  assign out_ptr   = r_out_ptr;
  assign out_tag   = r_out_tag;
  assign out_fault = r_out_fault;
  assign out_fcode = r_out_fcode;

`ifdef ADDRCALCSEC_CHK_FCNT_EN
  logic [15:0] r_fault_cnt;

  // Saturating count of faulted results accepted by the consumer; flushed results do not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_cnt <= '0;
    end else if (!flush && r_out_vld && out_rdy && r_out_fault && (r_fault_cnt != 16'hffff)) begin
      r_fault_cnt <= r_fault_cnt + 16'd1;
    end
  end

  assign fault_cnt = r_fault_cnt;
`else
  assign fault_cnt = 16'b0;
`endif

endmodule

// File: tb/tb_addrcalcsec_chk.sv
// Self-checking bench for addrcalcsec_chk: directed cases plus randomized
// traffic scored against a behavioural model of the bounds check.
module tb_addrcalcsec_chk;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_vld;
  logic        in_rdy;
  logic [64:0] in_ptr;
  logic [31:0] in_disp;
  logic [8:0]  in_tag;
  logic        in_chk_en;
  logic        out_vld;
  logic        out_rdy;
  logic [43:0] out_addr;
  logic [64:0] out_ptr;
  logic [8:0]  out_tag;
  logic        out_fault;
  logic [1:0]  out_fcode;
  logic [15:0] fault_cnt;

  addrcalcsec_chk #(.DISP_W(32), .TAG_W(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .in_ptr    (in_ptr),
    .in_disp   (in_disp),
    .in_tag    (in_tag),
    .in_chk_en (in_chk_en),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_addr  (out_addr),
    .out_ptr   (out_ptr),
    .out_tag   (out_tag),
    .out_fault (out_fault),
    .out_fcode (out_fcode),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [43:0] addr;
    logic [64:0] ptr;
    logic [8:0]  tag;
    logic [1:0]  fc;
  } exp_t;

  exp_t        q[$];
  int          n_vec;
  int          n_err;
  int unsigned m_cnt;
  logic [8:0]  tag_ctr;
  logic        last_in_acc;
  logic        prev_stall;
  logic [43:0] prev_addr;
  logic [64:0] prev_ptr;
  logic [8:0]  prev_tag;
  logic [1:0]  prev_fcode;
  logic        prev_fault;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [64:0] mkp(input logic [4:0] e, input logic [6:0] lo,
                                      input logic [6:0] hi, input logic onl,
                                      input logic [43:0] a);
    return {1'b0, e, lo, hi, onl, a};
  endfunction

  // Reference: address arithmetic and window rules computed with plain integers.
  function automatic exp_t model(input logic [64:0] p, input logic [31:0] d,
                                 input logic [8:0] tg, input logic chk_en);
    exp_t        r;
    logic [63:0] old_a;
    logic [63:0] sum;
    int unsigned e;
    int unsigned lo;
    int unsigned hi;
    int unsigned idx;
    old_a = {20'd0, p[43:0]};
    e     = 32'(p[63:59]);
    lo    = 32'(p[58:52]);
    hi    = 32'(p[51:45]);
    sum   = (old_a + {{32{d[31]}}, d}) & 64'h0000_0FFF_FFFF_FFFF;
    idx   = 32'(sum >> (e + 5)) & 32'h7f;
    r.fc  = 2'd0;
    if (chk_en && p[44]) begin
      if (hi < lo)                                   r.fc = 2'd3;
      else if ((sum >> (e + 12)) != (old_a >> (e + 12))) r.fc = 2'd2;
      else if (idx < lo || idx > hi)                 r.fc = 2'd1;
    end
    r.addr = sum[43:0];
    r.ptr  = {p[64:44], sum[43:0]};
    r.tag  = tg;
    return r;
  endfunction

  // One clock: score this cycle's handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    logic out_acc;
    logic in_acc;
    @(negedge clk);
    if (!rst) begin
      chk("fault_cnt", 65'(fault_cnt), 65'(m_cnt));
      chk("in_rdy", 65'(in_rdy), 65'(!(q.size() == 2 && !out_rdy)));
      if (out_vld) chk("out_vld_expected", 65'(q.size() != 0), 65'(1));
      if (prev_stall) begin
        chk("hold_vld",   65'(out_vld),   65'(1));
        chk("hold_addr",  65'(out_addr),  65'(prev_addr));
        chk("hold_ptr",   out_ptr,        prev_ptr);
        chk("hold_tag",   65'(out_tag),   65'(prev_tag));
        chk("hold_fcode", 65'(out_fcode), 65'(prev_fcode));
        chk("hold_fault", 65'(out_fault), 65'(prev_fault));
      end
    end
    out_acc = !rst && !flush && out_vld && out_rdy;
    if (out_acc && q.size() != 0) begin
      e = q.pop_front();
      chk("out_addr",  65'(out_addr),  65'(e.addr));
      chk("out_ptr",   out_ptr,        e.ptr);
      chk("out_tag",   65'(out_tag),   65'(e.tag));
      chk("out_fcode", 65'(out_fcode), 65'(e.fc));
      chk("out_fault", 65'(out_fault), 65'(e.fc != 2'd0));
`ifdef ADDRCALCSEC_CHK_FCNT_EN
      if (e.fc != 2'd0 && m_cnt != 32'd65535) m_cnt++;
`endif
    end
    in_acc = !rst && !flush && in_vld && in_rdy;
    if (rst || flush) q.delete();
    if (rst) m_cnt = 0;
    if (in_acc) q.push_back(model(in_ptr, in_disp, in_tag, in_chk_en));
    last_in_acc = in_acc;
    prev_stall  = !rst && !flush && out_vld && !out_rdy;
    prev_addr   = out_addr;
    prev_ptr    = out_ptr;
    prev_tag    = out_tag;
    prev_fcode  = out_fcode;
    prev_fault  = out_fault;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op();
    int unsigned e;
    int unsigned lo;
    int unsigned hi;
    int unsigned idx;
    int          sv;
    logic [63:0] r;
    e  = $urandom_range(0, 31);
    lo = $urandom_range(0, 127);
    if ($urandom_range(0, 7) == 0) hi = $urandom_range(0, 127);
    else                           hi = $urandom_range(lo, 127);
    idx = (hi >= lo) ? $urandom_range(lo, hi) : $urandom_range(0, 127);
    r = {$urandom(), $urandom()};
    r = r & 64'h0000_0FFF_FFFF_FFFF;
    r = (r & ~(64'h7f << (e + 5))) | (64'(idx) << (e + 5));
    case ($urandom_range(0, 2))
      0: begin
        sv      = int'($urandom_range(0, 15)) - 8;
        in_disp = 32'(sv <<< (e + 5));
      end
      1:       in_disp = $urandom();
      default: in_disp = 32'(int'($urandom_range(0, 64)) - 32);
    endcase
    in_ptr    = {1'($urandom_range(0, 1)), 5'(e), 7'(lo), 7'(hi),
                 1'($urandom_range(0, 7) != 0), r[43:0]};
    in_chk_en = 1'($urandom_range(0, 7) != 0);
    in_tag    = tag_ctr;
    tag_ctr   = tag_ctr + 9'd1;
  endtask

  // Single op into an empty pipe with fixed expected address/fcode and 2-cycle latency.
  task automatic single(input logic [64:0] p, input logic [31:0] d, input logic c,
                        input logic [43:0] xa, input logic [1:0] xf, input string nm);
    in_ptr = p; in_disp = d; in_chk_en = c; in_tag = tag_ctr; tag_ctr = tag_ctr + 9'd1;
    in_vld = 1'b1; out_rdy = 1'b1;
    tick();
    in_vld = 1'b0;
    chk({nm, "_lat1"}, 65'(out_vld), 65'(0));
    tick();
    chk({nm, "_vld"},   65'(out_vld),   65'(1));
    chk({nm, "_addr"},  65'(out_addr),  65'(xa));
    chk({nm, "_fcode"}, 65'(out_fcode), 65'(xf));
    chk({nm, "_fault"}, 65'(out_fault), 65'(xf != 2'd0));
    tick();
  endtask

  task automatic drain();
    in_vld = 1'b0; out_rdy = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", 65'(q.size()), 65'(0));
  endtask

  initial begin
    int sent;
    clk = 1'b0; rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    in_ptr = '0; in_disp = '0; in_tag = '0; in_chk_en = 1'b0;
    n_vec = 0; n_err = 0; m_cnt = 0; tag_ctr = 9'd1; last_in_acc = 1'b0;
    prev_stall = 1'b0; prev_addr = '0; prev_ptr = '0; prev_tag = '0;
    prev_fcode = '0; prev_fault = 1'b0;

    tick(); tick();
    chk("rst_out_vld",   65'(out_vld),   65'(0));
    chk("rst_out_addr",  65'(out_addr),  65'(0));
    chk("rst_out_ptr",   out_ptr,        65'(0));
    chk("rst_out_tag",   65'(out_tag),   65'(0));
    chk("rst_out_fault", 65'(out_fault), 65'(0));
    chk("rst_out_fcode", 65'(out_fcode), 65'(0));
    chk("rst_fault_cnt", 65'(fault_cnt), 65'(0));
    rst = 1'b0;
    tick();
    chk("rst_in_rdy", 65'(in_rdy), 65'(1));

    single(mkp(0, 2, 5, 1, 44'h40),  32'h40, 1'b1, 44'h80,  2'd0, "t1_in_win");
    single(mkp(0, 2, 5, 1, 44'h40),  32'ha0, 1'b1, 44'he0,  2'd1, "t2_above_hi");
    tick();
`ifdef ADDRCALCSEC_CHK_FCNT_EN
    chk("t2_fault_cnt", 65'(fault_cnt), 65'(1));
`else
    chk("t2_fault_cnt", 65'(fault_cnt), 65'(0));
`endif
    single(mkp(0, 2, 5, 1, 44'hfe0), 32'h40, 1'b1, 44'h1020, 2'd2, "t3_upper");
    single(mkp(0, 2, 5, 0, 44'hfe0), 32'h40, 1'b1, 44'h1020, 2'd0, "t3_no_onlow");
    single(mkp(0, 6, 3, 1, 44'h40),  32'h40, 1'b1, 44'h80,  2'd3, "t4_malf");
    single(mkp(0, 6, 3, 1, 44'h40),  32'h40, 1'b0, 44'h80,  2'd0, "t4_chk_off");
    single(mkp(0, 2, 5, 1, 44'h40),  32'hffffffe0, 1'b1, 44'h20, 2'd1, "t5_below_low");
    single(mkp(0, 2, 5, 1, 44'h0),   32'hbf, 1'b1, 44'hbf,  2'd0, "t6_hi_incl");
    single(mkp(0, 2, 5, 1, 44'h0),   32'hc0, 1'b1, 44'hc0,  2'd1, "t6_hi_plus1");
    single(mkp(31, 0, 127, 1, 44'hfff_ffff_fff0), 32'h20, 1'b1, 44'h10, 2'd2, "t7_wrap_e31");
    single(mkp(31, 1, 1, 1, 44'h100_0000_0000),   32'h0,  1'b1, 44'h100_0000_0000, 2'd1, "t8_e31_win");
    single(mkp(31, 16, 16, 1, 44'h100_0000_0000), 32'h0,  1'b1, 44'h100_0000_0000, 2'd0, "t8_e31_ok");

    // Back-to-back ops with a toggling consumer.
    sent = 0;
    rand_op();
    for (int cyc = 0; cyc < 200 && sent < 8; cyc++) begin
      out_rdy = 1'(cyc & 1);
      in_vld  = 1'b1;
      tick();
      if (last_in_acc) begin
        sent++;
        rand_op();
      end
    end
    chk("b2b_sent", 65'(sent), 65'(8));
    drain();

    // Flush with both stages full and the consumer stalled.
    out_rdy = 1'b0; in_vld = 1'b1;
    in_ptr = mkp(0, 6, 3, 1, 44'h40); in_disp = 32'h40; in_chk_en = 1'b1;
    for (int i = 0; i < 10 && q.size() < 2; i++) begin
      in_tag = tag_ctr; tag_ctr = tag_ctr + 9'd1;
      tick();
    end
    chk("flush_fill", 65'(q.size()), 65'(2));
    flush = 1'b1; out_rdy = 1'b1;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk("flush_out_vld", 65'(out_vld), 65'(0));
    tick();
    chk("flush_out_vld2", 65'(out_vld), 65'(0));
    chk("flush_in_rdy",   65'(in_rdy),  65'(1));

    // Reset mid-stream while the consumer is ready.
    out_rdy = 1'b0; in_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_op(); tick(); end
    rst = 1'b1; out_rdy = 1'b1;
    tick();
    chk("mid_rst_vld",   65'(out_vld),   65'(0));
    chk("mid_rst_addr",  65'(out_addr),  65'(0));
    chk("mid_rst_ptr",   out_ptr,        65'(0));
    chk("mid_rst_tag",   65'(out_tag),   65'(0));
    chk("mid_rst_fault", 65'(out_fault), 65'(0));
    chk("mid_rst_fcode", 65'(out_fcode), 65'(0));
    chk("mid_rst_cnt",   65'(fault_cnt), 65'(0));
    rst = 1'b0; in_vld = 1'b0;
    tick();
    chk("mid_rst_in_rdy", 65'(in_rdy), 65'(1));

    // Randomized traffic with random backpressure and occasional flush.
    rand_op();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_vld  = 1'($urandom_range(0, 3) != 0);
      out_rdy = 1'($urandom_range(0, 2) != 0);
      flush   = 1'($urandom_range(0, 39) == 0);
      tick();
      if (last_in_acc || flush) rand_op();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
